// File: rtl/vga_pixel_timing_if.sv
// Pixel-timing bundle between the raster generator and the colour source / DAC side.
interface vga_pixel_timing_if;
   logic [11:0] color_data;
   logic [9:0]  p_row;
   logic [9:0]  p_col;
   logic        p_tick;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic [11:0] rgb;
   logic        frame_start;

   // timing generator side
   modport master (
      input  color_data,
      output p_row, p_col, p_tick, hsync, vsync, video_on, rgb, frame_start
   );

   // colour source / display side
   modport slave (
      output color_data,
      input  p_row, p_col, p_tick, hsync, vsync, video_on, rgb, frame_start
   );
endinterface

// File: rtl/vga_pixel_timing.sv
// VGA raster timing: pixel-rate divider, h/v position counters and a one-tick
// registered output stage (sync, blanking, colour). p_row/p_col are the live
// counters so the colour source can compute color_data for the current pixel;
// the output stage then presents that pixel one tick later, aligned with sync.
module vga_pixel_timing #(
   parameter int H_VIS    = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_VIS    = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int TICK_DIV = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   vga_pixel_timing_if.master   vga
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
   localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
   localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_h_cnt;
   logic [9:0]       r_v_cnt;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_video_on;
   logic [11:0]      r_rgb;
   logic             r_frame_start;

   logic w_tick;
   logic w_h_last;
   logic w_v_last;
   logic w_vis;
   logic w_hs_active;
   logic w_vs_active;

   assign w_tick      = (r_div == DIV_LAST);
   assign w_h_last    = (r_h_cnt == H_LAST);
   assign w_v_last    = (r_v_cnt == V_LAST);
   assign w_vis       = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
   assign w_hs_active = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
   assign w_vs_active = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);

   // pixel-rate divider; the tick is the cycle where the divider sits at its last value
   always_ff @(posedge clk) begin
      if (reset)       r_div <= '0;
      else if (w_tick) r_div <= '0;
      else             r_div <= r_div + DIV_W'(1);
   end

   // raster position, advanced once per pixel tick, line wrap carries into rows
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_tick) begin
         if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
         end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
         end
      end
   end

   // output stage: decoded from the pre-advance position, held between ticks
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hsync    <= 1'b1;
         r_vsync    <= 1'b1;
         r_video_on <= 1'b0;
         r_rgb      <= '0;
      end else if (w_tick) begin
         r_hsync    <= ~w_hs_active;
         r_vsync    <= ~w_vs_active;
         r_video_on <= w_vis;
         r_rgb      <= w_vis ? vga.color_data : 12'h000;
      end
   end

   // frame marker, high for the one clk after the counters wrap to (0,0)
   always_ff @(posedge clk) begin
      if (reset) r_frame_start <= 1'b0;
      else       r_frame_start <= w_tick && w_h_last && w_v_last;
   end

   assign vga.p_tick      = w_tick;
   assign vga.p_col       = r_h_cnt;
   assign vga.p_row       = r_v_cnt;
   assign vga.hsync       = r_hsync;
   assign vga.vsync       = r_vsync;
   assign vga.video_on    = r_video_on;
   assign vga.rgb         = r_rgb;
   assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Randomized bench for vga_pixel_timing. A reduced-geometry instance is checked
// every clk against an arithmetic model (position = elapsed ticks mod frame);
// a default-geometry instance is spot-checked on its first lines.
module tb_vga_pixel_timing;

   localparam int TD = 4;
   localparam int HV = 16, HF = 4, HS = 6, HB = 4;
   localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic clk = 1'b0;
   logic reset;
   logic rst_d;

   vga_pixel_timing_if vif ();
   vga_pixel_timing_if vif_d ();

   vga_pixel_timing #(
      .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .TICK_DIV(TD)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .vga   (vif)
   );

   vga_pixel_timing u_dut_d (
      .clk   (clk),
      .reset (rst_d),
      .vga   (vif_d)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic vis_f(input int p);
      return ((p % HT) < HV) && ((p / HT) < VV);
   endfunction

   function automatic logic hs_f(input int p);
      int h;
      h = p % HT;
      return !((h >= HV + HF) && (h < HV + HF + HS));
   endfunction

   function automatic logic vs_f(input int p);
      int v;
      v = p / HT;
      return !((v >= VV + VF) && (v < VV + VF + VS));
   endfunction

   // model state: clks since reset release, expected colour register
   int          c = 0;
   logic [11:0] exp_rgb = '0;
   int          mode = 0;
   int          clk_no = 0;
   int          last_fs = -1;
   int          hs_low = 0;

   task automatic drive_color();
      int pos;
      pos = (c / TD) % FRAME;
      case (mode)
         0:       vif.color_data = 12'($urandom);
         1:       vif.color_data = {2'b00, 10'(pos % HT)};
         default: vif.color_data = 12'hFFF;
      endcase
   endtask

   task automatic step();
      logic tick_edge;
      int   pos_b, k, pos, pp;
      tick_edge = !reset && ((c % TD) == TD - 1);
      pos_b     = (c / TD) % FRAME;
      @(posedge clk);
      clk_no++;
      if (reset) begin
         c       = 0;
         exp_rgb = '0;
      end else begin
         if (tick_edge) exp_rgb = vis_f(pos_b) ? vif.color_data : 12'h000;
         c++;
      end
      #1;
      k   = c / TD;
      pos = k % FRAME;
      check("p_tick", 32'(vif.p_tick), 32'((c % TD) == TD - 1));
      check("p_col", 32'(vif.p_col), 32'(pos % HT));
      check("p_row", 32'(vif.p_row), 32'(pos / HT));
      check("rgb", 32'(vif.rgb), 32'(exp_rgb));
      check("frame_start", 32'(vif.frame_start),
            32'((c > 0) && (c % TD == 0) && (k % FRAME == 0)));
      if (k == 0) begin
         check("video_on", 32'(vif.video_on), 32'(0));
         check("hsync", 32'(vif.hsync), 32'(1));
         check("vsync", 32'(vif.vsync), 32'(1));
      end else begin
         pp = (k - 1) % FRAME;
         check("video_on", 32'(vif.video_on), 32'(vis_f(pp)));
         check("hsync", 32'(vif.hsync), 32'(hs_f(pp)));
         check("vsync", 32'(vif.vsync), 32'(vs_f(pp)));
      end
      if (reset) begin
         last_fs = -1;
         hs_low  = 0;
      end else begin
         if (vif.frame_start) begin
            if (last_fs >= 0) check("fs_period", 32'(clk_no - last_fs), 32'(FRAME * TD));
            last_fs = clk_no;
         end
         if (!vif.hsync) hs_low++;
         else if (hs_low > 0) begin
            check("hs_width", 32'(hs_low), 32'(HS * TD));
            hs_low = 0;
         end
      end
      drive_color();
   endtask

   // default-geometry spot checks: sync/blank edges and widths on real 640x480 timing
   logic d_hs_prev = 1'b1;
   logic d_vo_prev = 1'b0;
   int   d_low = 0;
   always @(negedge clk) begin
      if (!rst_d) begin
         if (!vif_d.hsync && d_hs_prev) check("d_hs_fall_col", 32'(vif_d.p_col), 32'(657));
         if (!vif_d.hsync) d_low++;
         else if (d_low > 0) begin
            check("d_hs_width", 32'(d_low), 32'(96 * 4));
            d_low = 0;
         end
         if (!vif_d.video_on && d_vo_prev) check("d_vo_fall_col", 32'(vif_d.p_col), 32'(641));
         check("d_rgb", 32'(vif_d.rgb), vif_d.video_on ? 32'h0FFF : 32'h0);
         d_hs_prev = vif_d.hsync;
         d_vo_prev = vif_d.video_on;
      end
   end

   initial begin
      int guard;
      reset = 1'b1;
      rst_d = 1'b1;
      vif_d.color_data = 12'hFFF;
      mode = 0;
      drive_color();
      repeat (3) step();
      @(negedge clk);
      reset = 1'b0;
      rst_d = 1'b0;

      mode = 0;
      repeat (FRAME * TD + 50) step();
      mode = 1;
      repeat (FRAME * TD + 50) step();
      mode = 2;
      repeat (FRAME * TD + 50) step();

      mode  = 0;
      guard = 0;
      while (!(((c / TD) % FRAME) == 5 * HT + 10 && (c % TD) == 1) && guard < 2 * FRAME * TD) begin
         step();
         guard++;
      end
      check("midframe_reach", 32'(guard < 2 * FRAME * TD), 32'(1));
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      repeat (FRAME * TD + 50) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
